// File: rtl/matrix_stream_feeder.sv
// Holds two n x n matrices and streams A row-major / B column-major element
// pairs to a multiplier over an out_stb/in_ack handshake.
module matrix_stream_feeder #(
    parameter int unsigned LOG_SIZE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [2*LOG_SIZE-1:0] wr_addr,
    input  logic [31:0]           wr_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           a,
    output logic [31:0]           b,
    output logic                  out_stb,
    input  logic                  in_ack
);

    localparam int unsigned AW = 2 * LOG_SIZE;
    localparam int unsigned N  = 1 << AW;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic            stb_q, stb_d;

    logic [31:0]     mem_a [N];
    logic [31:0]     mem_b [N];

    logic [AW-1:0]   fetch_idx;
    logic [AW-1:0]   fetch_bidx;
    logic            load;
    logic [31:0]     a_rd;
    logic [31:0]     b_rd;

    // Storage is deliberately not reset; writes only land while idle.
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == IDLE)) begin
            if (wr_sel) begin
                mem_b[wr_addr] <= wr_data;
            end else begin
                mem_a[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            stb_q   <= stb_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        stb_d     = stb_q;
        fetch_idx = '0;
        load      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    idx_d   = '0;
                    stb_d   = 1'b1;
                    load    = 1'b1;
                end
            end
            SEND: begin
                if (stb_q && in_ack) begin
                    if (idx_q == '1) begin
                        state_d = FINISH;
                        stb_d   = 1'b0;
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        fetch_idx = idx_q + 1'b1;
                        load      = 1'b1;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Column-major B index is the row-major index with row/col halves swapped.
        fetch_bidx = {fetch_idx[LOG_SIZE-1:0], fetch_idx[AW-1:LOG_SIZE]};
        a_rd       = mem_a[fetch_idx];
        b_rd       = mem_b[fetch_bidx];

        // A write coinciding with start is forwarded so element 0 sees it.
        if ((state_q == IDLE) && wr_en && !wr_sel && (wr_addr == fetch_idx)) begin
            a_rd = wr_data;
        end
        if ((state_q == IDLE) && wr_en && wr_sel && (wr_addr == fetch_bidx)) begin
            b_rd = wr_data;
        end

        if (load) begin
            a_d = a_rd;
            b_d = b_rd;
        end
    end

    assign a       = a_q;
    assign b       = b_q;
    assign out_stb = stb_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FINISH);

endmodule

// File: tb/tb_matrix_stream_feeder.sv
// Directed bench for matrix_stream_feeder with LOG_SIZE=2 (4x4 matrices).
module tb_matrix_stream_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        wr_sel;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_stb;
    logic        in_ack;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    matrix_stream_feeder #(.LOG_SIZE(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .a       (a),
        .b       (b),
        .out_stb (out_stb),
        .in_ack  (in_ack)
    );

    typedef struct {
        logic        start;
        logic        in_ack;
        logic        e_stb;
        logic        e_busy;
        logic        e_done;
        logic        e_ab;
        logic [31:0] e_a;
        logic [31:0] e_b;
    } vec_t;

    vec_t tbl[$];

    logic [31:0] exp_a [16];
    logic [31:0] exp_b [16] = '{
        32'h10, 32'h14, 32'h18, 32'h1C, 32'h11, 32'h15, 32'h19, 32'h1D,
        32'h12, 32'h16, 32'h1A, 32'h1E, 32'h13, 32'h17, 32'h1B, 32'h1F
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic ack, input logic we,
                         input logic sel, input logic [3:0] ad, input logic [31:0] d);
        start   = s;
        in_ack  = ack;
        wr_en   = we;
        wr_sel  = sel;
        wr_addr = ad;
        wr_data = d;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_elem(input string tag, input int k);
        chk($sformatf("%s.k%0d.stb", tag, k), {31'b0, out_stb}, 32'd1);
        chk($sformatf("%s.k%0d.busy", tag, k), {31'b0, busy}, 32'd1);
        chk($sformatf("%s.k%0d.done", tag, k), {31'b0, done}, 32'd0);
        chk($sformatf("%s.k%0d.a", tag, k), a, exp_a[k]);
        chk($sformatf("%s.k%0d.b", tag, k), b, exp_b[k]);
    endtask

    task automatic expect_ctl(input string tag, input logic stb, input logic bsy, input logic dn);
        chk($sformatf("%s.stb", tag), {31'b0, out_stb}, {31'b0, stb});
        chk($sformatf("%s.busy", tag), {31'b0, busy}, {31'b0, bsy});
        chk($sformatf("%s.done", tag), {31'b0, done}, {31'b0, dn});
    endtask

    // Element k0 is currently presented; accept it and every later one.
    task automatic run_from(input string tag, input int k0);
        for (int k = k0 + 1; k < 16; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
            step();
            expect_elem(tag, k);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        step();
        expect_ctl({tag, ".finish"}, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        step();
        expect_ctl({tag, ".idle"}, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vec_t v;
        for (int k = 0; k < 16; k++) exp_a[k] = 32'(k + 1);

        // Main stream: start, then in_ack held high throughout.
        v = '{start: 1'b1, in_ack: 1'b1, e_stb: 1'b1, e_busy: 1'b1, e_done: 1'b0,
              e_ab: 1'b1, e_a: exp_a[0], e_b: exp_b[0]};
        tbl.push_back(v);
        for (int k = 1; k < 16; k++) begin
            v = '{start: 1'b0, in_ack: 1'b1, e_stb: 1'b1, e_busy: 1'b1, e_done: 1'b0,
                  e_ab: 1'b1, e_a: exp_a[k], e_b: exp_b[k]};
            tbl.push_back(v);
        end
        v = '{start: 1'b0, in_ack: 1'b1, e_stb: 1'b0, e_busy: 1'b1, e_done: 1'b1,
              e_ab: 1'b0, e_a: 32'd0, e_b: 32'd0};
        tbl.push_back(v);
        v = '{start: 1'b0, in_ack: 1'b1, e_stb: 1'b0, e_busy: 1'b0, e_done: 1'b0,
              e_ab: 1'b0, e_a: 32'd0, e_b: 32'd0};
        tbl.push_back(v);
        tbl.push_back(v);

        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        #1;
        expect_ctl("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.a", a, 32'd0);
        chk("reset.b", b, 32'd0);
        step();
        rst = 1'b1;
        step();

        for (int k = 0; k < 16; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 4'(k), exp_a[k]);
            step();
        end
        for (int k = 0; k < 16; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 4'(k), 32'h10 + 32'(k));
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        step();
        expect_ctl("loaded", 1'b0, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            drive(tbl[i].start, tbl[i].in_ack, 1'b0, 1'b0, 4'd0, 32'd0);
            step();
            expect_ctl($sformatf("main[%0d]", i), tbl[i].e_stb, tbl[i].e_busy, tbl[i].e_done);
            if (tbl[i].e_ab) begin
                chk($sformatf("main[%0d].a", i), a, tbl[i].e_a);
                chk($sformatf("main[%0d].b", i), b, tbl[i].e_b);
            end
        end

        // Stall at k=5 for three cycles.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        step();
        expect_elem("stall", 0);
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
            step();
            expect_elem("stall", k);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
            step();
            expect_elem("stall.hold", 5);
        end
        run_from("stall", 5);

        // Start and a write during SEND are both ignored.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        step();
        expect_elem("ign", 0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 32'h0000FFFF);
        step();
        expect_elem("ign.hold", 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        step();
        expect_elem("ign", 1);
        run_from("ign", 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        step();
        expect_elem("rerun", 0);
        run_from("rerun", 0);

        // in_ack with nothing presented has no effect.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
            step();
            expect_ctl($sformatf("idle_ack[%0d]", i), 1'b0, 1'b0, 1'b0);
        end

        // Asynchronous reset at k=7.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        step();
        expect_elem("abort", 0);
        for (int k = 1; k <= 7; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
            step();
            expect_elem("abort", k);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        expect_ctl("abort.async", 1'b0, 1'b0, 1'b0);
        chk("abort.async.a", a, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            expect_ctl($sformatf("abort.held[%0d]", i), 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b1;
        step();
        expect_ctl("abort.released", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        step();
        expect_elem("after_abort", 0);
        run_from("after_abort", 0);

        // Write coinciding with start is visible in element 0.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 32'h000000AA);
        exp_a[0] = 32'h000000AA;
        step();
        expect_elem("wrstart", 0);
        run_from("wrstart", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
